// File: rtl/audio_pkg.sv
// Shared encodings for the voice scheduler: per-voice lifecycle states,
// controller FSM states and the default FCW width.
package audio_pkg;

    localparam int FCW_WIDTH_DEFAULT = 24;

    typedef enum logic [1:0] {
        V_FREE      = 2'd0,
        V_STARTING  = 2'd1,
        V_ACTIVE    = 2'd2,
        V_RELEASING = 2'd3
    } voice_state_e;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ALLOC      = 3'd1,
        S_STEAL_RST  = 3'd2,
        S_START_WAIT = 3'd3,
        S_OFF_SEARCH = 3'd4
    } sched_state_e;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder; used for both free-voice search and
// note-off match search.
module prio_enc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Allocates phase-accumulator voices for note-on/note-off commands, drives
// per-voice FCW/start/release/reset and retires voices once they finish.
module voice_scheduler
    import audio_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int FCW_WIDTH  = FCW_WIDTH_DEFAULT,
    parameter int VID_W      = $clog2(NUM_VOICES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_off,
    input  logic [FCW_WIDTH-1:0]            cmd_fcw,
    output logic [NUM_VOICES*FCW_WIDTH-1:0] voice_fcw,
    output logic [NUM_VOICES-1:0]           voice_start,
    output logic [NUM_VOICES-1:0]           voice_release,
    output logic [NUM_VOICES-1:0]           voice_reset,
    input  logic [NUM_VOICES-1:0]           voice_valid,
    input  logic [NUM_VOICES-1:0]           voice_finished,
    output logic [NUM_VOICES-1:0]           active_mask,
    output logic                            off_miss
);

    sched_state_e         state_q, state_d;
    voice_state_e         vstate_q [NUM_VOICES];
    voice_state_e         vstate_d [NUM_VOICES];
    logic [FCW_WIDTH-1:0] fcw_q    [NUM_VOICES];
    logic [FCW_WIDTH-1:0] fcw_d    [NUM_VOICES];
    logic [FCW_WIDTH-1:0] cmd_fcw_q, cmd_fcw_d;
    logic [VID_W-1:0]     tgt_q, tgt_d;
    logic [VID_W-1:0]     steal_ptr_q, steal_ptr_d;
    logic [NUM_VOICES-1:0] retire_q, retire_d;

    logic [NUM_VOICES-1:0] free_vec, match_vec, tgt_onehot, free_onehot, match_onehot;
    logic [NUM_VOICES-1:0] steal_rst_vec, enter_vec;
    logic                  free_found, match_found;
    logic [VID_W-1:0]      free_idx, match_idx;

    always_comb begin
        free_vec     = '0;
        match_vec    = '0;
        tgt_onehot   = '0;
        free_onehot  = '0;
        match_onehot = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            free_vec[v]     = (vstate_q[v] == V_FREE);
            match_vec[v]    = (vstate_q[v] == V_ACTIVE) && (fcw_q[v] == cmd_fcw_q);
            tgt_onehot[v]   = (tgt_q == VID_W'(v));
            free_onehot[v]  = free_found && (free_idx == VID_W'(v));
            match_onehot[v] = match_found && (match_idx == VID_W'(v));
        end
    end

    prio_enc #(.WIDTH(NUM_VOICES), .IDX_W(VID_W)) u_free_enc (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    prio_enc #(.WIDTH(NUM_VOICES), .IDX_W(VID_W)) u_match_enc (
        .req   (match_vec),
        .found (match_found),
        .idx   (match_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Stealing only advances steal_ptr; the free path leaves it untouched.
    always_comb begin
        state_d     = state_q;
        cmd_fcw_d   = cmd_fcw_q;
        tgt_d       = tgt_q;
        steal_ptr_d = steal_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_fcw_d = cmd_fcw;
                    state_d   = cmd_off ? S_OFF_SEARCH : S_ALLOC;
                end
            end
            S_ALLOC: begin
                if (free_found) begin
                    tgt_d   = free_idx;
                    state_d = S_START_WAIT;
                end else begin
                    tgt_d       = steal_ptr_q;
                    steal_ptr_d = steal_ptr_q + 1'b1;
                    state_d     = S_STEAL_RST;
                end
            end
            S_STEAL_RST:  state_d = S_START_WAIT;
            S_START_WAIT: if (voice_valid[tgt_q]) state_d = S_IDLE;
            S_OFF_SEARCH: state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = (state_q == S_IDLE) && !rst;
        voice_start   = (state_q == S_START_WAIT) ? tgt_onehot : '0;
        steal_rst_vec = (state_q == S_STEAL_RST) ? tgt_onehot : '0;
        voice_reset   = retire_q | steal_rst_vec;
        voice_release = (state_q == S_OFF_SEARCH) ? match_onehot : '0;
        off_miss      = (state_q == S_OFF_SEARCH) && !match_found;
        enter_vec     = '0;
        if (state_q == S_ALLOC) enter_vec = free_onehot;
        else if (state_q == S_STEAL_RST) enter_vec = tgt_onehot;
        for (int v = 0; v < NUM_VOICES; v++) active_mask[v] = (vstate_q[v] == V_ACTIVE);
    end

    // Later assignments take priority: a steal overrides a same-cycle retirement.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            vstate_d[v] = vstate_q[v];
            fcw_d[v]    = fcw_q[v];
            retire_d[v] = voice_finished[v] && (vstate_q[v] == V_RELEASING)
                          && !retire_q[v] && !steal_rst_vec[v];
            if (retire_q[v])      vstate_d[v] = V_FREE;
            if (voice_release[v]) vstate_d[v] = V_RELEASING;
            if (enter_vec[v]) begin
                vstate_d[v] = V_STARTING;
                fcw_d[v]    = cmd_fcw_q;
            end
            if (voice_start[v] && voice_valid[v]) vstate_d[v] = V_ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_fcw_q   <= '0;
            tgt_q       <= '0;
            steal_ptr_q <= '0;
            retire_q    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                vstate_q[v] <= V_FREE;
                fcw_q[v]    <= '0;
            end
        end else begin
            cmd_fcw_q   <= cmd_fcw_d;
            tgt_q       <= tgt_d;
            steal_ptr_q <= steal_ptr_d;
            retire_q    <= retire_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                vstate_q[v] <= vstate_d[v];
                fcw_q[v]    <= fcw_d[v];
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_fcw_pack
        assign voice_fcw[g*FCW_WIDTH +: FCW_WIDTH] = fcw_q[g];
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: allocation, stealing, note-off,
// retirement, back-pressure and mid-operation reset.
module tb_voice_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_off = 1'b0;
    logic [23:0] cmd_fcw = '0;
    logic [95:0] voice_fcw;
    logic [3:0]  voice_start, voice_release, voice_reset;
    logic [3:0]  voice_valid = '0;
    logic [3:0]  voice_finished = '0;
    logic [3:0]  active_mask;
    logic        off_miss;

    int checks = 0;
    int passes = 0;

    voice_scheduler #(.NUM_VOICES(4), .FCW_WIDTH(24)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_off        (cmd_off),
        .cmd_fcw        (cmd_fcw),
        .voice_fcw      (voice_fcw),
        .voice_start    (voice_start),
        .voice_release  (voice_release),
        .voice_reset    (voice_reset),
        .voice_valid    (voice_valid),
        .voice_finished (voice_finished),
        .active_mask    (active_mask),
        .off_miss       (off_miss)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        voice_valid = '0;
        voice_finished = '0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
    endtask

    // Issues a note-on, records which voice was started and any reset pulses
    // seen on the way, then acknowledges after ack_delay cycles.
    task automatic note_on(input logic [23:0] fcw, input int ack_delay,
                           output logic [3:0] started, output logic [3:0] resets);
        int n = 0;
        resets = '0;
        wait_ready();
        cmd_valid = 1'b1; cmd_off = 1'b0; cmd_fcw = fcw;
        tick();
        cmd_valid = 1'b0;
        while (voice_start == '0 && n < 50) begin resets |= voice_reset; tick(); n++; end
        resets |= voice_reset;
        started = voice_start;
        repeat (ack_delay) tick();
        voice_valid = started;
        tick();
        voice_valid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL rst_ready: got %b expected 0", cmd_ready); else passes++;
        checks++; if ({voice_start, voice_release, voice_reset, active_mask, off_miss} !== 17'h0)
            $display("[TB] FAIL rst_outputs: got %h expected 0", {voice_start, voice_release, voice_reset, active_mask, off_miss}); else passes++;
        checks++; if (voice_fcw !== 96'h0) $display("[TB] FAIL rst_fcw: got %h expected 0", voice_fcw); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rst_ready_after: got %b expected 1", cmd_ready); else passes++;
    endtask

    task automatic test_note_on();
        cmd_valid = 1'b1; cmd_off = 1'b0; cmd_fcw = 24'h001000;
        tick();
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL on_ready_alloc: got %b expected 0", cmd_ready); else passes++;
        tick();
        checks++; if (voice_start !== 4'b0001) $display("[TB] FAIL on_start: got %b expected 0001", voice_start); else passes++;
        checks++; if (voice_fcw[23:0] !== 24'h001000) $display("[TB] FAIL on_fcw0: got %h expected 001000", voice_fcw[23:0]); else passes++;
        tick();
        checks++; if (voice_start !== 4'b0001) $display("[TB] FAIL on_start_held: got %b expected 0001", voice_start); else passes++;
        voice_valid = 4'b0001;
        tick();
        voice_valid = '0;
        checks++; if (voice_start !== 4'b0000) $display("[TB] FAIL on_start_drop: got %b expected 0000", voice_start); else passes++;
        checks++; if (active_mask !== 4'b0001) $display("[TB] FAIL on_active: got %b expected 0001", active_mask); else passes++;
        checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL on_ready_back: got %b expected 1", cmd_ready); else passes++;
    endtask

    task automatic test_steal();
        logic [3:0] st, rs;
        do_reset();
        note_on(24'h000100, 0, st, rs);
        note_on(24'h000200, 1, st, rs);
        note_on(24'h000300, 0, st, rs);
        note_on(24'h000400, 2, st, rs);
        checks++; if (st !== 4'b1000) $display("[TB] FAIL steal_fill_v3: got %b expected 1000", st); else passes++;
        checks++; if (active_mask !== 4'b1111) $display("[TB] FAIL steal_full: got %b expected 1111", active_mask); else passes++;
        note_on(24'h000500, 0, st, rs);
        checks++; if (rs !== 4'b0001) $display("[TB] FAIL steal_reset0: got %b expected 0001", rs); else passes++;
        checks++; if (st !== 4'b0001) $display("[TB] FAIL steal_start0: got %b expected 0001", st); else passes++;
        checks++; if (voice_fcw[23:0] !== 24'h000500) $display("[TB] FAIL steal_fcw0: got %h expected 000500", voice_fcw[23:0]); else passes++;
        note_on(24'h000600, 0, st, rs);
        checks++; if ({rs, st} !== 8'b0010_0010) $display("[TB] FAIL steal_v1: got %b expected 00100010", {rs, st}); else passes++;
        checks++; if (voice_fcw[47:24] !== 24'h000600) $display("[TB] FAIL steal_fcw1: got %h expected 000600", voice_fcw[47:24]); else passes++;
    endtask

    task automatic test_release_retire();
        logic [3:0] st, rs;
        do_reset();
        note_on(24'h000100, 0, st, rs);
        note_on(24'h000200, 0, st, rs);
        note_on(24'h000300, 0, st, rs);
        wait_ready();
        cmd_valid = 1'b1; cmd_off = 1'b1; cmd_fcw = 24'h000200;
        tick();
        cmd_valid = 1'b0;
        checks++; if ({voice_release, off_miss, voice_reset} !== 9'b0010_0_0000)
            $display("[TB] FAIL off_release1: got %b expected 001000000", {voice_release, off_miss, voice_reset}); else passes++;
        tick();
        checks++; if (voice_release !== 4'b0000) $display("[TB] FAIL off_release_pulse: got %b expected 0000", voice_release); else passes++;
        checks++; if (active_mask !== 4'b0101) $display("[TB] FAIL off_active: got %b expected 0101", active_mask); else passes++;
        voice_finished = 4'b0010;
        tick();
        checks++; if (voice_reset !== 4'b0010) $display("[TB] FAIL retire_reset: got %b expected 0010", voice_reset); else passes++;
        tick();
        voice_finished = '0;
        checks++; if (voice_reset !== 4'b0000) $display("[TB] FAIL retire_pulse: got %b expected 0000", voice_reset); else passes++;
        note_on(24'h000700, 0, st, rs);
        checks++; if ({rs, st} !== 8'b0000_0010) $display("[TB] FAIL retire_realloc: got %b expected 00000010", {rs, st}); else passes++;
        checks++; if (voice_fcw[47:24] !== 24'h000700) $display("[TB] FAIL retire_fcw1: got %h expected 000700", voice_fcw[47:24]); else passes++;
    endtask

    task automatic test_off_miss();
        wait_ready();
        cmd_valid = 1'b1; cmd_off = 1'b1; cmd_fcw = 24'h000ABC;
        tick();
        cmd_valid = 1'b0;
        checks++; if ({off_miss, voice_release, voice_reset, cmd_ready} !== 10'b1_0000_0000_0)
            $display("[TB] FAIL miss_pulse: got %b expected 1000000000", {off_miss, voice_release, voice_reset, cmd_ready}); else passes++;
        tick();
        checks++; if ({off_miss, cmd_ready} !== 2'b01) $display("[TB] FAIL miss_done: got %b expected 01", {off_miss, cmd_ready}); else passes++;
        cmd_valid = 1'b1; cmd_fcw = 24'h000300;
        tick();
        cmd_valid = 1'b0;
        checks++; if (voice_release !== 4'b0100) $display("[TB] FAIL miss_release2: got %b expected 0100", voice_release); else passes++;
        tick();
        cmd_valid = 1'b1; cmd_fcw = 24'h000300;
        tick();
        cmd_valid = 1'b0;
        checks++; if ({off_miss, voice_release} !== 5'b1_0000)
            $display("[TB] FAIL miss_releasing: got %b expected 10000", {off_miss, voice_release}); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int n = 0;
        wait_ready();
        cmd_valid = 1'b1; cmd_off = 1'b0; cmd_fcw = 24'h000800;
        tick();
        cmd_fcw = 24'h000900;
        while (voice_start == '0 && n < 50) begin
            if (cmd_ready !== 1'b0) bad++;
            tick(); n++;
        end
        repeat (10) begin
            if (cmd_ready !== 1'b0 || voice_start !== 4'b1000) bad++;
            tick();
        end
        checks++; if (bad != 0) $display("[TB] FAIL b2b_ready_low: got %0d bad cycles expected 0", bad); else passes++;
        checks++; if (voice_fcw[95:72] !== 24'h000800) $display("[TB] FAIL b2b_fcw3: got %h expected 000800", voice_fcw[95:72]); else passes++;
        voice_valid = 4'b1000;
        tick();
        voice_valid = '0;
        checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL b2b_ready_back: got %b expected 1", cmd_ready); else passes++;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++; if (voice_reset !== 4'b0001) $display("[TB] FAIL b2b_steal_reset: got %b expected 0001", voice_reset); else passes++;
        tick();
        checks++; if (voice_start !== 4'b0001) $display("[TB] FAIL b2b_start0: got %b expected 0001", voice_start); else passes++;
        checks++; if (voice_fcw[23:0] !== 24'h000900) $display("[TB] FAIL b2b_fcw0: got %h expected 000900", voice_fcw[23:0]); else passes++;
        voice_valid = 4'b0001;
        tick();
        voice_valid = '0;
        repeat (3) tick();
        checks++; if ({voice_start, cmd_ready, active_mask} !== 9'b0000_1_1011)
            $display("[TB] FAIL b2b_no_dup: got %b expected 000011011", {voice_start, cmd_ready, active_mask}); else passes++;
    endtask

    task automatic test_mid_reset();
        logic [3:0] st, rs;
        do_reset();
        note_on(24'h000100, 0, st, rs);
        note_on(24'h000200, 0, st, rs);
        wait_ready();
        cmd_valid = 1'b1; cmd_off = 1'b0; cmd_fcw = 24'h000300;
        tick();
        cmd_valid = 1'b0;
        repeat (2) tick();
        checks++; if (voice_start !== 4'b0100) $display("[TB] FAIL mrst_start2: got %b expected 0100", voice_start); else passes++;
        rst = 1'b1;
        tick();
        checks++; if ({voice_start, voice_release, voice_reset, active_mask, off_miss, cmd_ready} !== 18'h0)
            $display("[TB] FAIL mrst_outputs: got %h expected 0", {voice_start, voice_release, voice_reset, active_mask, off_miss, cmd_ready}); else passes++;
        checks++; if (voice_fcw !== 96'h0) $display("[TB] FAIL mrst_fcw: got %h expected 0", voice_fcw); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL mrst_ready: got %b expected 1", cmd_ready); else passes++;
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_steal();
        test_release_retire();
        test_off_miss();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
Allocates and sequences a bank of NUM_VOICES phase accumulators for polyphonic playback. Accepts note-on/note-off commands over a valid/ready handshake and picks a voice for each note. Per voice it drives the FCW and the start/release/reset controls, and retires voices once they report completion. Sits between the MMIO/command front end and the per-voice phase accumulator + sample buffer chain.

Parameters:
NUM_VOICES, 4, number of accumulator voices managed (power of two, 2..16)
FCW_WIDTH, 24, width of frequency control word
VID_W, $clog2(NUM_VOICES), voice index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  scheduler can accept a command this cycle
cmd_off  in  1  0 = note-on, 1 = note-off
cmd_fcw  in  FCW_WIDTH  note FCW; also the key used to match a note-off
voice_fcw  out  NUM_VOICES*FCW_WIDTH  per-voice FCW; voice v occupies bits [v*FCW_WIDTH +: FCW_WIDTH]
voice_start  out  NUM_VOICES  per-voice start request, level, held until acknowledged
voice_release  out  NUM_VOICES  per-voice one-cycle release pulse
voice_reset  out  NUM_VOICES  per-voice one-cycle reset pulse
voice_valid  in  NUM_VOICES  per-voice accumulator valid; first high after a start is the start acknowledge
voice_finished  in  NUM_VOICES  per-voice finished flag, sticky until that voice is reset
active_mask  out  NUM_VOICES  voices in ACTIVE state
off_miss  out  1  one-cycle pulse when a note-off matches no ACTIVE voice

Behaviour:
- Reset: every output = 0 and every voice_fcw = 0; all voices FREE; steal_ptr = 0; FSM = IDLE. cmd_ready = 0 during reset and 1 in the first cycle after it.
- Per-voice state: FREE, STARTING, ACTIVE, RELEASING. active_mask[v] = (state == ACTIVE).
- Command handshake:
  - cmd_ready = 1 only in IDLE.
  - A command is accepted on the edge where cmd_valid && cmd_ready; cmd_fcw and cmd_off are latched at that edge.
- Controller FSM: IDLE, ALLOC, STEAL_RST, START_WAIT, OFF_SEARCH.
- Note-on (IDLE -> ALLOC, one cycle):
  - If any voice is FREE, choose the lowest-index FREE voice v.
  - Otherwise choose v = steal_ptr and increment steal_ptr modulo NUM_VOICES.
  - Stealing happens regardless of the victim's state (ACTIVE or RELEASING).
- Steal path (ALLOC -> STEAL_RST): voice_reset[v] is pulsed for exactly one cycle, then the FSM enters START_WAIT.
- Free path (ALLOC -> START_WAIT): entered directly when a FREE voice was found.
- START_WAIT:
  - voice_fcw[v] <= latched FCW on entry; voice v = STARTING; voice_start[v] held high.
  - On the edge where voice_valid[v] = 1: drop voice_start[v], set voice v ACTIVE, return to IDLE.
  - Minimum note-on turnaround is 3 cycles with a FREE voice and 4 when stealing.
  - No timeout; while waiting, cmd_ready stays 0.
- Note-off (IDLE -> OFF_SEARCH, one cycle):
  - Find the lowest-index ACTIVE voice with voice_fcw == latched FCW.
  - Match: pulse voice_release[v] for one cycle, set voice v RELEASING.
  - No match: pulse off_miss. Voices in STARTING or RELEASING never match.
  - Either way, return to IDLE.
- Retirement, concurrent with the FSM:
  - When voice_finished[v] = 1 and voice v is RELEASING, pulse voice_reset[v] for one cycle and set voice v FREE the following cycle.
  - voice_finished on a voice in any other state is ignored.
- Collisions:
  - If retirement and a steal target the same voice in the same cycle, the steal wins. A single reset pulse is issued and the voice goes to STARTING, not FREE.
  - A retirement completing in the ALLOC cycle is not visible to that allocation; the steal decision uses pre-edge state.
- voice_reset, voice_release and voice_start are never asserted together on the same voice in the same cycle.
- Reset asserted mid-operation aborts everything: all pulses and requests drop at the next edge and all voices become FREE. The accumulators are reset separately by the top level.

Decomposition:
- Package audio_pkg: voice-state encodings (2 bits), FSM state encodings, the FCW_WIDTH default.
- One sub-module, prio_enc (parameterised lowest-set-bit encoder returning found + index). It is reused for both free-voice search and note-off match search.

Test Plan:
1. Reset, then note-on FCW=0x001000; model acks voice_valid[0] 2 cycles after start -> voice_fcw[0]=0x001000, voice_start[0] high until ack, active_mask=0001, cmd_ready back high 1 cycle after ack.
2. Four note-ons 0x100, 0x200, 0x300, 0x400, then note-on 0x500 -> voice_reset[0] pulse, voice_fcw[0]=0x500, voice_start[0]; steal_ptr=1; next overflow steals voice 1.
3. With voices 0..2 active, note-off 0x200 -> voice_release[1] single pulse, active_mask=101; assert voice_finished[1] -> voice_reset[1] pulse next cycle, voice 1 FREE, and the next note-on lands on voice 1.
4. Note-off 0xABC with no match -> off_miss one pulse, no release/reset pulses, cmd_ready returns after 2 cycles.
5. Assert cmd_valid continuously during START_WAIT with ack held off 10 cycles -> cmd_ready=0 throughout, no command lost or duplicated.
6. Assert rst while voice_start[2] is high -> all outputs 0 next edge, active_mask=0, cmd_ready=1 after deassert.
